// File: rtl/ps2_receiver.sv
// ps2_receiver -- PS/2 device-to-host frame receiver.
//
// Brings the raw PS2Clk/PS2Data pins into the clk domain through 2-FF
// synchronisers, then deglitches the clock. It deserialises 11-bit frames
// (start, 8 data bits LSB first, parity, stop) on falling edges of the
// filtered clock. Each good frame produces one byte with a one-cycle strobe.
//
// Optional feature: define PS2_PARITY_CHECK_EN to enforce odd parity.
// Without it, the parity bit is sampled and ignored, and only the stop bit
// is checked.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   ps2_clk   in   raw PS2Clk pin (async)
//   ps2_data  in   raw PS2Data pin (async)
//   rx_data   out  [7:0] last good byte, held until the next good frame
//   rx_valid  out  one-cycle pulse, rx_data updated
//   rx_err    out  one-cycle pulse, frame rejected (stop/parity/timeout)
//   busy      out  high while a frame is in progress
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronisers idle high, matching the bus idle level.
  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_data;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Clock deglitch: the filtered level flips on the FILTER_LEN-th
  // consecutive differing sample. Any agreeing sample restarts the run.
  logic          filt_clk_q;
  logic [FW-1:0] flt_cnt_q;
  logic          flip, sample_ev;

  always_comb begin
    flip      = (clk_sync_q != filt_clk_q) && (flt_cnt_q == FLT_LAST);
    sample_ev = flip && filt_clk_q;   // 1 -> 0 transition
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_q <= 1'b1;
      flt_cnt_q  <= '0;
    end else if (clk_sync_q == filt_clk_q) begin
      flt_cnt_q <= '0;
    end else if (flip) begin
      filt_clk_q <= clk_sync_q;
      flt_cnt_q  <= '0;
    end else begin
      flt_cnt_q <= flt_cnt_q + 1'b1;
    end
  end

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q, rx_err_q, busy_q;
  logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q;
  always_comb par_ok = ^{shift_q, par_q};   // odd parity over data + parity
`else
  always_comb par_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      // The counter saturates at TO_MAX and is serviced here first, so it
      // never wraps. A sampling event in the same cycle is dropped.
      if (state_q != IDLE && to_cnt_q == TO_MAX) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        rx_err_q  <= 1'b1;
        to_cnt_q  <= '0;
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else begin
        if (state_q == IDLE) to_cnt_q <= '0;
        else                 to_cnt_q <= sample_ev ? '0 : to_cnt_q + 1'b1;
        case (state_q)
          IDLE: if (sample_ev && !dat_sync_q) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
          DATA: if (sample_ev) begin
            shift_q <= {dat_sync_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) state_q <= PARITY;
            else                   bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          PARITY: if (sample_ev) begin
`ifdef PS2_PARITY_CHECK_EN
            par_q <= dat_sync_q;
`endif
            state_q <= STOP;
          end
          STOP: if (sample_ev) begin
            if (dat_sync_q && par_ok) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_err_q <= 1'b1;
            end
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver. The stimulus pushes the expected strobe
// (kind + rx_data) for each frame, and a negedge monitor pops and compares
// every rx_valid/rx_err pulse. PS/2 timing and the timeout are scaled down
// so the run stays short, and FILTER_LEN stays at 8.
module tb_ps2_receiver;
  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int H    = 40;     // half PS/2 bit period in clk cycles

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, busy;

  ps2_receiver #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [7:0] data; } exp_t;
  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_chk = 0, n_fail = 0;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (rx_valid || rx_err)) begin
      exp_t e;
      n_chk++;
      if (rx_valid && rx_err) begin
        n_fail++; $display("FAIL strobe_excl: valid=%0b err=%0b both high", rx_valid, rx_err);
      end else if (sb.size() == 0) begin
        n_fail++; $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%02h, none expected",
                           rx_valid, rx_err, rx_data);
      end else begin
        e = sb.pop_front();
        if (rx_err !== e.err || rx_data !== e.data) begin
          n_fail++;
          $display("FAIL strobe: got err=%0b data=%02h, want err=%0b data=%02h",
                   rx_err, rx_data, e.err, e.data);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++; $display("FAIL %s: got %02h want %02h", name, got, want);
    end
  endtask

  task automatic expect_ev(input logic err, input logic [7:0] d);
    exp_t e;
    e.err  = err;
    e.data = err ? last_good : d;
    if (!err) last_good = d;
    sb.push_back(e);
  endtask

  // Drive the first n bits of {stop, parity, byte, start}, LSB first.
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic par, input logic stp);
    send_bits({stp, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    cyc(3 * H);
  endtask

  initial begin
    cyc(4);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_valid", {7'd0, rx_valid}, 8'h00);
    chk("rst_err", {7'd0, rx_err}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    rst = 1'b0;
    cyc(20);

    // 1: single good frame
    expect_ev(1'b0, 8'h1D); frame(8'h1D, 1'b1, 1'b1);
    chk("t1_data", rx_data, 8'h1D);
    // 2: back-to-back
    expect_ev(1'b0, 8'hF0); frame(8'hF0, 1'b1, 1'b1);
    chk("t2_data0", rx_data, 8'hF0);
    expect_ev(1'b0, 8'h1D); frame(8'h1D, 1'b1, 1'b1);
    chk("t2_data1", rx_data, 8'h1D);
    // 3: bad parity
`ifdef PS2_PARITY_CHECK_EN
    expect_ev(1'b1, 8'h00);
`else
    expect_ev(1'b0, 8'h1D);
`endif
    frame(8'h1D, 1'b0, 1'b1);
    // 4: bad stop bit
    expect_ev(1'b1, 8'h00); frame(8'h29, 1'b0, 1'b0);
    chk("t4_busy", {7'd0, busy}, 8'h00);
    chk("t4_data_held", rx_data, 8'h1D);

    // 5: timeout after start + 4 data bits
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    ps2_data = 1'b1;
    cyc(2);
    chk("t5_busy_mid", {7'd0, busy}, 8'h01);
    expect_ev(1'b1, 8'h00);
    cyc(TO + 200);
    chk("t5_busy_after", {7'd0, busy}, 8'h00);
    chk("t5_sb_drained", 8'(sb.size()), 8'h00);
    expect_ev(1'b0, 8'h29); frame(8'h29, 1'b0, 1'b1);
    chk("t5_data", rx_data, 8'h29);

    // 6: short glitch in IDLE, then reset mid-frame
    ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1;
    cyc(30);
    chk("t6_glitch_busy", {7'd0, busy}, 8'h00);
    send_bits({1'b1, 1'b1, 8'h1D, 1'b0}, 4);
    cyc(2);
    chk("t6_busy_mid", {7'd0, busy}, 8'h01);
    rst = 1'b1; cyc(3);
    rst = 1'b0; last_good = 8'h00;
    cyc(2);
    chk("t6_rst_busy", {7'd0, busy}, 8'h00);
    chk("t6_rst_data", rx_data, 8'h00);
    ps2_data = 1'b1;
    cyc(4 * H);
    expect_ev(1'b0, 8'h1D); frame(8'h1D, 1'b1, 1'b1);
    chk("t6_data", rx_data, 8'h1D);

    cyc(50);
    chk("sb_empty", 8'(sb.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
